// File: rtl/quadrilatero_row_feeder_if.sv
// Row-feeder signal bundle: tile control, upstream row stream and skewer-facing outputs.
// The master modport drives the feeder; the slave modport is the feeder itself.
interface quadrilatero_row_feeder_if #(
  parameter int unsigned MESH_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K_WIDTH    = 9
);
  logic                             start_i;
  logic [K_WIDTH-1:0]               k_len_i;
  logic                             row_valid_i;
  logic                             row_ready_o;
  logic [MESH_WIDTH*DATA_WIDTH-1:0] row_data_i;
  logic                             stall_i;
  logic                             pump_o;
  logic [MESH_WIDTH*DATA_WIDTH-1:0] data_o;
  logic [MESH_WIDTH-1:0]            lane_valid_o;
  logic                             busy_o;
  logic                             done_o;
  logic [31:0]                      perf_bubble_o;

  modport master (
    output start_i, k_len_i, row_valid_i, row_data_i, stall_i,
    input  row_ready_o, pump_o, data_o, lane_valid_o, busy_o, done_o, perf_bubble_o
  );

  modport slave (
    input  start_i, k_len_i, row_valid_i, row_data_i, stall_i,
    output row_ready_o, pump_o, data_o, lane_valid_o, busy_o, done_o, perf_bubble_o
  );
endinterface

// File: rtl/quadrilatero_row_feeder.sv
// Feeds K rows of a tile into the mesh input skewer, then pumps MESH_WIDTH-1 zero rows to drain it.
// Optional bubble counter enabled by defining QUADRILATERO_FEEDER_PERF_EN.
module quadrilatero_row_feeder #(
  parameter int unsigned MESH_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_K      = 256,
  parameter int unsigned K_WIDTH    = $clog2(MAX_K + 1)
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  quadrilatero_row_feeder_if.slave bus
);
  localparam int unsigned DrainW = (MESH_WIDTH > 1) ? $clog2(MESH_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e             state_q, state_d;
  logic [K_WIDTH-1:0] k_q, k_d, row_cnt_q, row_cnt_d, k_clamped;
  logic [DrainW-1:0]  drain_cnt_q, drain_cnt_d;
  logic               done_q, done_d;
  logic               xfer, cur_v;

  assign k_clamped = (bus.k_len_i > K_WIDTH'(MAX_K)) ? K_WIDTH'(MAX_K) : bus.k_len_i;
  assign xfer      = (state_q == StFeed) & bus.row_valid_i & ~bus.stall_i;
  assign cur_v     = xfer;

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    row_cnt_d       = row_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    done_d          = 1'b0;
    bus.row_ready_o = 1'b0;
    bus.pump_o      = 1'b0;
    bus.data_o      = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (bus.k_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            k_d       = k_clamped;
            row_cnt_d = '0;
            state_d   = StFeed;
          end
        end
      end
      StFeed: begin
        bus.row_ready_o = ~bus.stall_i;
        if (xfer) begin
          bus.pump_o = 1'b1;
          bus.data_o = bus.row_data_i;
          row_cnt_d  = row_cnt_q + 1'b1;
          if (row_cnt_d == k_q) begin
            // A single-lane mesh has no skew to flush.
            if (MESH_WIDTH == 1) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d     = StDrain;
              drain_cnt_d = '0;
            end
          end
        end
      end
      StDrain: begin
        bus.pump_o = ~bus.stall_i;
        if (!bus.stall_i) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == DrainW'(int'(MESH_WIDTH) - 2)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      k_q         <= '0;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy_o = (state_q != StIdle);
  assign bus.done_o = done_q;

  // vh_q[j-1] mirrors skewer lane j; it shifts only when the skewer itself advances.
  if (MESH_WIDTH > 1) begin : g_vh
    logic [MESH_WIDTH-2:0] vh_q;
    logic [MESH_WIDTH-1:0] lanes;

    assign lanes            = {vh_q, cur_v};
    assign bus.lane_valid_o = lanes;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vh_q <= '0;
      end else if (bus.pump_o) begin
        vh_q <= lanes[MESH_WIDTH-2:0];
      end
    end
  end else begin : g_no_vh
    assign bus.lane_valid_o = cur_v;
  end

`ifdef QUADRILATERO_FEEDER_PERF_EN
  logic [31:0] bubble_q;
  logic        start_acc;

  assign start_acc = (state_q == StIdle) & bus.start_i & (bus.k_len_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bubble_q <= '0;
    end else if (start_acc) begin
      bubble_q <= '0;
    end else if ((state_q == StFeed) && !xfer && (bubble_q != '1)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bus.perf_bubble_o = bubble_q;
`else
  assign bus.perf_bubble_o = '0;
`endif

endmodule

// File: tb/tb_quadrilatero_row_feeder.sv
// Self-checking bench for quadrilatero_row_feeder: directed table, corner sequences and
// randomized traffic against a row/zero-count reference model.
module tb_quadrilatero_row_feeder;
  localparam int unsigned MW   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXK = 256;
  localparam int unsigned KW   = $clog2(MAXK + 1);
  localparam int unsigned RW   = MW * DW;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  quadrilatero_row_feeder_if #(.MESH_WIDTH(MW), .DATA_WIDTH(DW), .K_WIDTH(KW)) bus ();

  quadrilatero_row_feeder #(
    .MESH_WIDTH(MW),
    .DATA_WIDTH(DW),
    .MAX_K     (MAXK),
    .K_WIDTH   (KW)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: rows still owed, zero rows still owed, history of pumped real-data flags.
  bit          m_busy, m_done;
  int          m_rows, m_zeros;
  logic [31:0] m_bubble;
  bit          hist[$];

  logic          last_pump, last_ready, last_done, last_busy;
  logic [MW-1:0] last_lv;
  int            npumps;

  function automatic void chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [RW-1:0] row(input int i);
    logic [RW-1:0] r;
    for (int l = 0; l < MW; l++) r[l*DW +: DW] = 32'hA000_0000 | (32'(i) << 4) | 32'(l);
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int l = 0; l < MW; l++) r[l*DW +: DW] = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_rows = 0; m_zeros = 0; m_bubble = '0;
    hist.delete();
  endfunction

  // Drive one cycle from a negedge, check outputs 1ns later, advance the model at the posedge.
  task automatic cyc(input logic st, input logic [KW-1:0] kl, input logic rv, input logic sl,
                     input logic [RW-1:0] rd);
    logic          e_feed, e_pump, e_ready;
    logic [MW-1:0] e_lv;
    logic [RW-1:0] e_data;
    logic [31:0]   e_perf;
    bus.start_i = st; bus.k_len_i = kl; bus.row_valid_i = rv; bus.stall_i = sl;
    bus.row_data_i = rd;
    #1;
    e_feed  = m_busy && (m_rows > 0);
    e_ready = e_feed && !sl;
    e_pump  = e_feed ? (rv && !sl) : (m_busy && !sl);
    e_data  = (e_feed && e_pump) ? rd : '0;
    e_lv[0] = e_feed && e_pump;
    for (int i = 1; i < MW; i++) e_lv[i] = (i - 1 < hist.size()) ? hist[i-1] : 1'b0;
`ifdef QUADRILATERO_FEEDER_PERF_EN
    e_perf = m_bubble;
`else
    e_perf = '0;
`endif
    chk("pump_o", RW'(bus.pump_o), RW'(e_pump));
    chk("row_ready_o", RW'(bus.row_ready_o), RW'(e_ready));
    chk("data_o", bus.data_o, e_data);
    chk("lane_valid_o", RW'(bus.lane_valid_o), RW'(e_lv));
    chk("busy_o", RW'(bus.busy_o), RW'(m_busy));
    chk("done_o", RW'(bus.done_o), RW'(m_done));
    chk("perf_bubble_o", RW'(bus.perf_bubble_o), RW'(e_perf));
    last_pump = bus.pump_o; last_ready = bus.row_ready_o; last_lv = bus.lane_valid_o;
    last_done = bus.done_o; last_busy = bus.busy_o;
    if (bus.pump_o) npumps++;
    @(posedge clk_i);
    if (e_pump) begin
      hist.push_front(e_lv[0]);
      if (hist.size() > MW) void'(hist.pop_back());
    end
    m_done = 0;
    if (!m_busy) begin
      if (st) begin
        if (kl == '0) m_done = 1;
        else begin
          m_busy = 1; m_rows = (int'(kl) > MAXK) ? MAXK : int'(kl);
          m_zeros = MW - 1; m_bubble = '0;
        end
      end
    end else if (m_rows > 0) begin
      if (rv && !sl) begin
        m_rows--;
        if (m_rows == 0 && m_zeros == 0) begin m_busy = 0; m_done = 1; end
      end else if (m_bubble != '1) m_bubble++;
    end else if (!sl) begin
      m_zeros--;
      if (m_zeros == 0) begin m_busy = 0; m_done = 1; end
    end
    @(negedge clk_i);
  endtask

  task automatic reset_check(input string nm);
    chk({nm, ".pump_o"}, RW'(bus.pump_o), '0);
    chk({nm, ".row_ready_o"}, RW'(bus.row_ready_o), '0);
    chk({nm, ".data_o"}, bus.data_o, '0);
    chk({nm, ".lane_valid_o"}, RW'(bus.lane_valid_o), '0);
    chk({nm, ".busy_o"}, RW'(bus.busy_o), '0);
    chk({nm, ".done_o"}, RW'(bus.done_o), '0);
    chk({nm, ".perf_bubble_o"}, RW'(bus.perf_bubble_o), '0);
  endtask

  typedef struct {
    logic          st;
    logic [KW-1:0] k;
    logic          rv;
    logic          sl;
    logic          e_pump;
    logic [MW-1:0] e_lv;
    logic          e_done;
    logic          e_busy;
  } vec_t;

  vec_t          vt[10];
  logic [MW-1:0] lv_seq[$];
  logic [MW-1:0] exp_seq[7];
  logic [MW-1:0] exp_k1[4];
  logic [31:0]   exp_perf;
  int            done_at;

  initial begin
    vt[0] = '{1'b1, KW'(4), 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vt[1] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1};
    vt[2] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b1};
    vt[3] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b1};
    vt[4] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1};
    vt[5] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1};
    vt[6] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b1, 4'b1100, 1'b0, 1'b1};
    vt[7] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1};
    vt[8] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
    vt[9] = '{1'b0, KW'(0), 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    exp_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    exp_k1  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef QUADRILATERO_FEEDER_PERF_EN
    exp_perf = 32'd2;
`else
    exp_perf = 32'd0;
`endif

    bus.start_i = 0; bus.k_len_i = '0; bus.row_valid_i = 1; bus.stall_i = 0;
    bus.row_data_i = '0;
    model_reset();
    npumps = 0;
    @(negedge clk_i);
    #1 reset_check("reset");
    @(negedge clk_i);
    rst_ni = 1;

    // Back-to-back k=4 tile from the table.
    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].st, vt[i].k, vt[i].rv, vt[i].sl, row(i));
      chk($sformatf("b2b[%0d].pump", i), RW'(last_pump), RW'(vt[i].e_pump));
      chk($sformatf("b2b[%0d].lv", i), RW'(last_lv), RW'(vt[i].e_lv));
      chk($sformatf("b2b[%0d].done", i), RW'(last_done), RW'(vt[i].e_done));
      chk($sformatf("b2b[%0d].busy", i), RW'(last_busy), RW'(vt[i].e_busy));
    end

    // Bubbles: k=2 with a two-cycle gap between rows.
    npumps = 0;
    cyc(1, KW'(2), 0, 0, '0);
    cyc(0, '0, 1, 0, row(0));
    for (int g = 0; g < 2; g++) begin
      cyc(0, '0, 0, 0, row(9));
      chk("bubble.gap_lv", RW'(last_lv), RW'(4'b0010));
    end
    cyc(0, '0, 1, 0, row(1));
    for (int d = 0; d < 3; d++) cyc(0, '0, 0, 0, '0);
    cyc(0, '0, 0, 0, '0);
    chk("bubble.done", RW'(last_done), RW'(1'b1));
    chk("bubble.pumps", RW'(npumps), RW'(5));
    chk("bubble.perf", RW'(bus.perf_bubble_o), RW'(exp_perf));

    // Stall three cycles in FEED and three in DRAIN.
    lv_seq.delete();
    done_at = -1;
    for (int c = 0; c < 40; c++) begin
      logic sl;
      sl = ((c >= 1 && c <= 3) || (c >= 8 && c <= 10));
      cyc(c == 0, KW'(4), 1, sl, row(c));
      if (sl) begin
        chk("stall.ready", RW'(last_ready), '0);
        chk("stall.pump", RW'(last_pump), '0);
      end
      if (last_pump) lv_seq.push_back(last_lv);
      if (last_done) begin done_at = c; break; end
    end
    chk("stall.done_cycle", RW'(done_at), RW'(14));
    chk("stall.npump", RW'(lv_seq.size()), RW'(7));
    for (int i = 0; i < 7 && i < lv_seq.size(); i++)
      chk($sformatf("stall.lv[%0d]", i), RW'(lv_seq[i]), RW'(exp_seq[i]));

    // k=0 start.
    cyc(1, '0, 1, 0, row(3));
    chk("k0.busy0", RW'(last_busy), '0);
    cyc(0, '0, 1, 0, row(3));
    chk("k0.done", RW'(last_done), RW'(1'b1));
    chk("k0.busy1", RW'(last_busy), '0);
    chk("k0.pump", RW'(last_pump), '0);

    // Ignored start in FEED, restart in the done cycle.
    cyc(1, KW'(1), 0, 0, '0);
    cyc(1, KW'(3), 0, 0, '0);
    cyc(0, '0, 1, 0, row(5));
    for (int d = 0; d < 3; d++) cyc(0, '0, 0, 0, '0);
    cyc(1, KW'(2), 0, 0, '0);
    chk("restart.done", RW'(last_done), RW'(1'b1));
    cyc(0, '0, 1, 0, row(6));
    chk("restart.ready", RW'(last_ready), RW'(1'b1));
    chk("restart.busy", RW'(last_busy), RW'(1'b1));
    for (int c = 0; c < 20 && m_busy; c++) cyc(0, '0, 1, 0, row(7));
    cyc(0, '0, 0, 0, '0);

    // Reset after the second drain pump of a k=1 tile.
    cyc(1, KW'(1), 0, 0, '0);
    cyc(0, '0, 1, 0, row(8));
    cyc(0, '0, 0, 0, '0);
    cyc(0, '0, 0, 0, '0);
    bus.row_valid_i = 1; bus.start_i = 0; bus.stall_i = 0;
    rst_ni = 0;
    #1 reset_check("midreset");
    model_reset();
    @(negedge clk_i);
    rst_ni = 1;
    cyc(0, '0, 1, 0, '0);
    chk("midreset.no_done", RW'(last_done), '0);
    lv_seq.delete();
    cyc(1, KW'(1), 1, 0, '0);
    for (int c = 0; c < 10 && m_busy; c++) begin
      cyc(0, '0, 1, 0, row(c));
      if (last_pump) lv_seq.push_back(last_lv);
    end
    chk("k1.npump", RW'(lv_seq.size()), RW'(4));
    for (int i = 0; i < 4 && i < lv_seq.size(); i++)
      chk($sformatf("k1.lv[%0d]", i), RW'(lv_seq[i]), RW'(exp_k1[i]));

    // Randomized traffic, occasionally with an over-range k.
    for (int c = 0; c < 3000; c++) begin
      logic [KW-1:0] kl;
      kl = KW'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) kl = KW'($urandom_range(257, 511));
      cyc($urandom_range(0, 5) == 0, kl, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          rand_row());
    end
    for (int c = 0; c < 2000 && m_busy; c++) cyc(0, '0, 1, 0, rand_row());
    chk("final.idle", RW'(m_busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/quadrilatero_row_feeder.md
# quadrilatero_row_feeder

Streams a tile of K operand rows into the mesh input skewer and then drains it. It sits directly upstream of the skewer: it drives the skewer's `pump` and row-data inputs, then issues MESH_WIDTH-1 zero-row pumps so the skewed tail reaches the systolic mesh. It also produces per-lane valid flags that track which skewer output lanes currently carry real data.

## Interface
- MESH_WIDTH, 4, lanes per row; must be ≥1
- DATA_WIDTH, 32, bits per element
- MAX_K, 256, maximum rows per tile
- K_WIDTH, $clog2(MAX_K+1), width of the row-count input
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start tile; sampled only in IDLE
- k_len_i  in  K_WIDTH  rows in this tile; latched with start_i
- row_valid_i  in  1  upstream row available
- row_ready_o  out  1  feeder accepts a row this cycle
- row_data_i  in  MESH_WIDTH×DATA_WIDTH  upstream row
- stall_i  in  1  mesh stall; no pump while high
- pump_o  out  1  connects to the skewer's pump input
- data_o  out  MESH_WIDTH×DATA_WIDTH  connects to the skewer's row input
- lane_valid_o  out  MESH_WIDTH  lane i of the skewer output holds real data
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle tile-complete pulse
- perf_bubble_o  out  32  bubble counter (see Configuration)

## Operation
- FSM states: IDLE, FEED, DRAIN.
- **IDLE**
  - With start_i=1 and k_len_i≠0: latch k_len_i, clear row_cnt, go to FEED.
  - With start_i=1 and k_len_i=0: pulse done_o on the next cycle and stay in IDLE.
- **FEED**
  - row_ready_o = !stall_i.
  - A transfer is row_valid_i & row_ready_o. On a transfer, pump_o=1, data_o=row_data_i, and row_cnt increments.
  - With no transfer, pump_o=0, data_o=0, and the skewer holds.
  - On the transfer where row_cnt reaches k: go to DRAIN with drain_cnt=0. If MESH_WIDTH==1, go to IDLE instead and pulse done_o.
- **DRAIN**
  - row_ready_o=0, data_o=0, pump_o = !stall_i.
  - drain_cnt increments on each pump.
  - After the (MESH_WIDTH-1)th pump: go to IDLE and pulse done_o.
- start_i is ignored outside IDLE.
- **Valid tracking**
  - cur_v = pump_o & (state==FEED).
  - lane_valid_o[0] = cur_v (combinational).
  - Shift register vh[1..MESH_WIDTH-1] advances only on pump_o: vh[1] ← cur_v, vh[j] ← vh[j-1].
  - lane_valid_o[i] = vh[i] for i ≥ 1.
  - After a full drain, vh is all zero.
- Outside FEED/DRAIN: pump_o=0, data_o=0, row_ready_o=0.
- busy_o = (state≠IDLE).

## Timing
- Reset values: state=IDLE, counters=0, vh=0, done_o=0, busy_o=0, perf counter=0. All other outputs are 0 while in IDLE.
- Reset mid-tile aborts immediately with no done_o. The downstream skewer is reset by the same rst_ni.
- pump_o, data_o and row_ready_o are combinational from state, stall_i and row_valid_i. There are no combinational paths from row_data_i other than to data_o.
- done_o is registered. It asserts in the cycle after the final pump (or after start with k=0), which is the same cycle busy_o returns to 0.
- A new start_i is accepted in the same cycle done_o is high.
- Minimum tile duration with no stalls or bubbles: k + MESH_WIDTH-1 pump cycles. done_o follows one cycle later.
- stall_i during a transfer attempt blocks the transfer (ready low); no data is lost.
- k_len_i > MAX_K is not legal. The implementation clamps it to MAX_K.

## Configuration
- QUADRILATERO_FEEDER_PERF_EN
  - **Defined:** perf_bubble_o counts FEED cycles without a transfer, from any cause (row_valid_i low or stall_i high). It clears on an accepted start, saturates at 2^32-1, and holds its value in IDLE.
  - **Undefined:** perf_bubble_o is tied to 0 and no counter is synthesised.

## Test plan
All scenarios use MESH_WIDTH=4.
- **Back-to-back tile:** k=4, row_valid_i always high, no stall.
  - 7 consecutive pumps: rows r0–r3, then 3 zero rows.
  - lane_valid_o sequence: 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - done_o on cycle 8.
- **Bubbles:** k=2, row_valid_i low for 2 cycles between r0 and r1.
  - No pump during the gap; lane_valid_o is held.
  - 5 pumps total.
  - perf_bubble_o=2 with the macro defined, 0 without it.
- **Stall in FEED and DRAIN:** stall_i=1 for 3 cycles in each phase.
  - row_ready_o=0 and pump_o=0 throughout each stall.
  - Pump sequence identical to the no-stall run.
  - Tile finishes 6 cycles later than the no-stall run.
- **k=0 start:** done_o pulses next cycle, busy_o never rises, no pump.
- **Restart and ignored start:** start_i during FEED is ignored. A start asserted in the done_o cycle begins the next tile, with row_ready_o high on the following cycle.
- **Reset mid-DRAIN:** rst_ni low for 1 cycle after the second drain pump.
  - All outputs return to reset values; no done_o.
  - A subsequent k=1 tile gives lane_valid_o sequence 0001, 0010, 0100, 1000.
